// File: rtl/gelato_ram_arbiter_pkg.sv
// Shared types and helpers for the multi-core Gelato RAM arbiter.
package gelato_ram_arbiter_pkg;

   localparam int ARB_STAT_WIDTH = 32;

   typedef logic [ARB_STAT_WIDTH-1:0] stat_t;

   // Saturating increment used by the optional statistics counters.
   function automatic stat_t sat_inc(input stat_t v);
      return (v == '1) ? v : v + stat_t'(1);
   endfunction

endpackage

// File: rtl/gelato_ram_arbiter_if.sv
// Bus bundle between the per-core frontends, the arbiter and the external RAM port.
// slave  = arbiter view; master = environment (frontends + RAM) view.
interface gelato_ram_arbiter_if #(
   parameter int NUM_CORES  = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_CORES-1:0]            core_req_valid;
   logic [NUM_CORES*ADDR_WIDTH-1:0] core_req_addr;
   logic [NUM_CORES-1:0]            core_req_ready;
   logic [NUM_CORES-1:0]            core_resp_valid;
   logic [DATA_WIDTH-1:0]           core_resp_data;
   logic                            ram_req_valid;
   logic [ADDR_WIDTH-1:0]           ram_req_addr;
   logic                            ram_req_ready;
   logic                            ram_resp_valid;
   logic [DATA_WIDTH-1:0]           ram_resp_data;

   modport slave (
      input  core_req_valid, core_req_addr, ram_req_ready, ram_resp_valid, ram_resp_data,
      output core_req_ready, core_resp_valid, core_resp_data, ram_req_valid, ram_req_addr
   );

   modport master (
      output core_req_valid, core_req_addr, ram_req_ready, ram_resp_valid, ram_resp_data,
      input  core_req_ready, core_resp_valid, core_resp_data, ram_req_valid, ram_req_addr
   );
endinterface

// File: rtl/gelato_ram_arbiter_id_fifo.sv
// Small synchronous FIFO holding the core ID of each in-flight RAM request.
// Push is ignored when full and pop is ignored when empty.
module gelato_ram_arbiter_id_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointer and occupancy next-state.
   always_comb begin
      // NOTE: every combinationally written signal gets a default first so no latch can be inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write.
   // NOTE: storage is not reset; an entry is only read after it has been written, and count gates validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end
endmodule

// File: rtl/gelato_ram_arbiter.sv
// Round-robin arbiter letting NUM_CORES frontends share one in-order RAM port.
// Responses are steered back using an ID FIFO of the granted cores.
// Optional build macro: GELATO_ARB_STATS_EN adds stat_grants / stat_full_cycles counters.
module gelato_ram_arbiter
   import gelato_ram_arbiter_pkg::*;
#(
   parameter int NUM_CORES   = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int OUTSTANDING = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rdy,
   gelato_ram_arbiter_if.slave       bus,
   output logic                      err_orphan_resp
`ifdef GELATO_ARB_STATS_EN
   ,
   output logic [NUM_CORES*ARB_STAT_WIDTH-1:0] stat_grants,
   output logic [ARB_STAT_WIDTH-1:0]           stat_full_cycles
`endif
);
   localparam int ID_W = $clog2(NUM_CORES);
   typedef logic [ID_W-1:0] core_id_t;

   core_id_t rr_ptr_q, rr_ptr_d;
   core_id_t winner, fifo_head;
   logic     any_valid, handshake, fifo_full, fifo_empty, resp_pop;
   logic     orphan_q, orphan_d;
   int       idx;

   assign any_valid = |bus.core_req_valid;
   assign handshake = bus.ram_req_valid && bus.ram_req_ready;
   assign resp_pop  = bus.ram_resp_valid && !fifo_empty;

   // Round-robin pick: scan from rr_ptr upward; iterating downward lets the nearest hit win.
   always_comb begin
      winner = '0;
      idx    = 0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % NUM_CORES;
         if (bus.core_req_valid[idx[ID_W-1:0]]) winner = idx[ID_W-1:0];
      end
   end

   // Request/response outputs and arbiter next-state.
   always_comb begin
      bus.ram_req_valid   = rdy && !fifo_full && any_valid;
      bus.ram_req_addr    = '0;
      bus.core_req_ready  = '0;
      bus.core_resp_valid = '0;
      bus.core_resp_data  = bus.ram_resp_data;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (any_valid && winner == core_id_t'(i))
            bus.ram_req_addr = bus.core_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         bus.core_req_ready[i]  = handshake && (winner == core_id_t'(i));
         bus.core_resp_valid[i] = resp_pop && (fifo_head == core_id_t'(i));
      end
      rr_ptr_d = rr_ptr_q;
      if (handshake)
         rr_ptr_d = (winner == core_id_t'(NUM_CORES - 1)) ? '0 : winner + core_id_t'(1);
      orphan_d = orphan_q || (bus.ram_resp_valid && fifo_empty);
   end

   assign err_orphan_resp = orphan_q;

   // Round-robin pointer and sticky orphan flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         orphan_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         orphan_q <= orphan_d;
      end
   end

   gelato_ram_arbiter_id_fifo #(
      .DEPTH (OUTSTANDING),
      .WIDTH (ID_W)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (handshake),
      .din_i   (winner),
      .pop_i   (resp_pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

`ifdef GELATO_ARB_STATS_EN
   stat_t grant_cnt_q [NUM_CORES];
   stat_t grant_cnt_d [NUM_CORES];
   stat_t full_cnt_q, full_cnt_d;

   // Saturating per-core grant counters and full-stall counter.
   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         grant_cnt_d[i] = grant_cnt_q[i];
         if (handshake && winner == core_id_t'(i)) grant_cnt_d[i] = sat_inc(grant_cnt_q[i]);
         stat_grants[i*ARB_STAT_WIDTH +: ARB_STAT_WIDTH] = grant_cnt_q[i];
      end
      full_cnt_d = (any_valid && fifo_full) ? sat_inc(full_cnt_q) : full_cnt_q;
   end

   assign stat_full_cycles = full_cnt_q;

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CORES; i++) grant_cnt_q[i] <= '0;
         full_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CORES; i++) grant_cnt_q[i] <= grant_cnt_d[i];
         full_cnt_q <= full_cnt_d;
      end
   end
`endif
endmodule

// File: tb/tb_gelato_ram_arbiter.sv
// Scoreboard bench for gelato_ram_arbiter (NUM_CORES=4, OUTSTANDING=4).
// Stimulus pushes expected grants/responses into queues; a negedge monitor pops and compares.
module tb_gelato_ram_arbiter;
   import gelato_ram_arbiter_pkg::*;

   localparam int NC = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n;
   logic rdy;
   logic err_orphan_resp;
`ifdef GELATO_ARB_STATS_EN
   logic [NC*ARB_STAT_WIDTH-1:0] stat_grants;
   logic [ARB_STAT_WIDTH-1:0]    stat_full_cycles;
`endif

   gelato_ram_arbiter_if #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   gelato_ram_arbiter #(
      .NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rdy             (rdy),
      .bus             (bus),
      .err_orphan_resp (err_orphan_resp)
`ifdef GELATO_ARB_STATS_EN
      ,
      .stat_grants      (stat_grants),
      .stat_full_cycles (stat_full_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          core;
      logic [31:0] addr;
   } grant_t;

   typedef struct {
      logic [NC-1:0] onehot;
      logic [31:0]   data;
   } resp_t;

   grant_t exp_grant_q[$];
   resp_t  exp_resp_q[$];
   int     n_checks = 0;
   int     n_fail   = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_addr(input int i, input logic [31:0] a);
      bus.core_req_addr[i*AW +: AW] = a;
   endtask

   task automatic exp_grant(input int core, input logic [31:0] addr);
      grant_t g;
      g.core = core;
      g.addr = addr;
      exp_grant_q.push_back(g);
   endtask

   task automatic exp_resp(input logic [NC-1:0] onehot, input logic [31:0] data);
      resp_t r;
      r.onehot = onehot;
      r.data   = data;
      exp_resp_q.push_back(r);
   endtask

   // Monitor: compare every grant and every routed response against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.core_req_ready != '0) begin
            if (exp_grant_q.size() == 0) begin
               check("unexpected_grant", 64'(bus.core_req_ready), 64'h0);
            end else begin
               grant_t g;
               g = exp_grant_q.pop_front();
               check("grant_core", 64'(bus.core_req_ready), 64'(1) << g.core);
               check("grant_addr", 64'(bus.ram_req_addr), 64'(g.addr));
            end
         end
         if (bus.core_resp_valid != '0) begin
            if (exp_resp_q.size() == 0) begin
               check("unexpected_resp", 64'(bus.core_resp_valid), 64'h0);
            end else begin
               resp_t r;
               r = exp_resp_q.pop_front();
               check("resp_core", 64'(bus.core_resp_valid), 64'(r.onehot));
               check("resp_data", 64'(bus.core_resp_data), 64'(r.data));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n              = 1'b0;
      rdy                = 1'b1;
      bus.core_req_valid = '0;
      bus.core_req_addr  = '0;
      bus.ram_req_ready  = 1'b0;
      bus.ram_resp_valid = 1'b0;
      bus.ram_resp_data  = '0;

      // Reset state: all outputs idle.
      sample();
      check("rst_ram_req_valid", 64'(bus.ram_req_valid), 64'h0);
      check("rst_ram_req_addr", 64'(bus.ram_req_addr), 64'h0);
      check("rst_core_req_ready", 64'(bus.core_req_ready), 64'h0);
      check("rst_core_resp_valid", 64'(bus.core_resp_valid), 64'h0);
      check("rst_err_orphan", 64'(err_orphan_resp), 64'h0);
      step();
      rst_n = 1'b1;
      step();

      // Round-robin across all four cores until the FIFO fills.
      for (int i = 0; i < NC; i++) begin
         set_addr(i, 32'h100 * (i + 1));
         exp_grant(i, 32'h100 * (i + 1));
      end
      bus.core_req_valid = 4'b1111;
      bus.ram_req_ready  = 1'b1;
      repeat (4) step();
      sample();
      check("full_no_req_valid", 64'(bus.ram_req_valid), 64'h0);
      check("full_no_ready", 64'(bus.core_req_ready), 64'h0);
      step();
      bus.core_req_valid = '0;

      // Ordered responses routed back 0,1,2,3.
      bus.ram_resp_valid = 1'b1;
      for (int i = 0; i < NC; i++) begin
         bus.ram_resp_data = 32'hA0 + 32'(i);
         exp_resp(4'(1 << i), 32'hA0 + 32'(i));
         step();
      end
      bus.ram_resp_valid = 1'b0;
      sample();
      check("no_orphan_after_drain", 64'(err_orphan_resp), 64'h0);
      step();

      // Full FIFO with a simultaneous pop: no grant that cycle, grant on the next.
      set_addr(0, 32'h500);
      bus.core_req_valid = 4'b0001;
      repeat (4) exp_grant(0, 32'h500);
      repeat (4) step();
      bus.core_req_valid = 4'b0100;
      set_addr(2, 32'h340);
      bus.ram_resp_valid = 1'b1;
      bus.ram_resp_data  = 32'hB0;
      exp_resp(4'b0001, 32'hB0);
      sample();
      check("full_pop_no_grant", 64'(bus.ram_req_valid), 64'h0);
      step();
      bus.ram_resp_valid = 1'b0;
      exp_grant(2, 32'h340);
      step();
      bus.core_req_valid = '0;
      bus.ram_resp_valid = 1'b1;
      bus.ram_resp_data  = 32'hC0; exp_resp(4'b0001, 32'hC0); step();
      bus.ram_resp_data  = 32'hC1; exp_resp(4'b0001, 32'hC1); step();
      bus.ram_resp_data  = 32'hC2; exp_resp(4'b0001, 32'hC2); step();
      bus.ram_resp_data  = 32'hC3; exp_resp(4'b0100, 32'hC3); step();
      bus.ram_resp_valid = 1'b0;

      // rdy gating: rr_ptr is 3 here, so core 3 wins first and moves it to 0.
      set_addr(3, 32'h600);
      bus.core_req_valid = 4'b1000;
      exp_grant(3, 32'h600);
      step();
      rdy = 1'b0;
      set_addr(1, 32'h700);
      set_addr(3, 32'h800);
      bus.core_req_valid = 4'b1010;
      bus.ram_resp_valid = 1'b1;
      bus.ram_resp_data  = 32'hD0;
      exp_resp(4'b1000, 32'hD0);
      sample();
      check("rdy_low_req_valid", 64'(bus.ram_req_valid), 64'h0);
      check("rdy_low_ready", 64'(bus.core_req_ready), 64'h0);
      step();
      bus.ram_resp_valid = 1'b0;
      sample();
      check("rdy_low_req_valid2", 64'(bus.ram_req_valid), 64'h0);
      step();
      rdy = 1'b1;
      exp_grant(1, 32'h700);
      step();
      exp_grant(3, 32'h800);
      step();
      bus.core_req_valid = '0;
      bus.ram_resp_valid = 1'b1;
      bus.ram_resp_data  = 32'hE0; exp_resp(4'b0010, 32'hE0); step();
      bus.ram_resp_data  = 32'hE1; exp_resp(4'b1000, 32'hE1); step();
      bus.ram_resp_valid = 1'b0;

      // Orphan response with an empty FIFO sets a sticky flag.
      bus.ram_resp_valid = 1'b1;
      bus.ram_resp_data  = 32'hF0;
      sample();
      check("orphan_no_resp_valid", 64'(bus.core_resp_valid), 64'h0);
      step();
      bus.ram_resp_valid = 1'b0;
      sample();
      check("orphan_flag_set", 64'(err_orphan_resp), 64'h1);
      step();
      step();
      sample();
      check("orphan_flag_sticky", 64'(err_orphan_resp), 64'h1);
      step();

      // Two requests in flight, then asynchronous reset mid-operation.
      set_addr(0, 32'h900);
      set_addr(1, 32'hA00);
      bus.core_req_valid = 4'b0011;
      exp_grant(0, 32'h900);
      exp_grant(1, 32'hA00);
      step();
      step();
      bus.core_req_valid = '0;
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_clears_orphan", 64'(err_orphan_resp), 64'h0);
      check("reset_core_resp_valid", 64'(bus.core_resp_valid), 64'h0);
      check("reset_ram_req_valid", 64'(bus.ram_req_valid), 64'h0);
      step();
      rst_n = 1'b1;
      step();

      // Discarded IDs: the next response is an orphan.
      bus.ram_resp_valid = 1'b1;
      bus.ram_resp_data  = 32'hF1;
      sample();
      check("post_reset_no_route", 64'(bus.core_resp_valid), 64'h0);
      step();
      bus.ram_resp_valid = 1'b0;
      sample();
      check("post_reset_orphan", 64'(err_orphan_resp), 64'h1);
      step();

      // rr_ptr restarts at 0 after reset: core 0 beats core 2.
      set_addr(0, 32'hB00);
      set_addr(2, 32'hC00);
      bus.core_req_valid = 4'b0101;
      exp_grant(0, 32'hB00);
      step();
      bus.core_req_valid = '0;
      bus.ram_resp_valid = 1'b1;
      bus.ram_resp_data  = 32'h1234_5678;
      exp_resp(4'b0001, 32'h1234_5678);
      step();
      bus.ram_resp_valid = 1'b0;
      step();

      check("grant_queue_drained", 64'(exp_grant_q.size()), 64'h0);
      check("resp_queue_drained", 64'(exp_resp_q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/gelato_ram_arbiter.md
Name: gelato_ram_arbiter

Overview:
- Parametrised successor of the single-core Gelato top-level RAM hookup.
- Lets NUM_CORES frontends share one RAM port.
- Round-robin arbitration of fetch requests; in-order RAM responses routed back to the requesting core through an internal ID FIFO.
- Sits between the per-core frontends and the external RAM interface in the multi-core Gelato top.

Parameters:
- NUM_CORES, 4, number of requesting frontends; must be 2 or more.
- ADDR_WIDTH, 32, RAM byte-address width.
- DATA_WIDTH, 32, RAM response data width.
- OUTSTANDING, 4, maximum in-flight RAM requests (ID FIFO depth); must be a power of two.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low blocks new grants
- core_req_valid  in  NUM_CORES  per-core request valid
- core_req_addr  in  NUM_CORES*ADDR_WIDTH  per-core address; core i uses slice i
- core_req_ready  out  NUM_CORES  per-core request accepted
- core_resp_valid  out  NUM_CORES  per-core response strobe
- core_resp_data  out  DATA_WIDTH  response data, shared by all cores
- ram_req_valid  out  1  RAM request valid
- ram_req_addr  out  ADDR_WIDTH  RAM request address
- ram_req_ready  in  1  RAM accepts request
- ram_resp_valid  in  1  RAM response valid; in order, cannot be stalled
- ram_resp_data  in  DATA_WIDTH  RAM response data
- err_orphan_resp  out  1  sticky flag: response arrived with no request in flight

Behaviour:
- Reset (async, rst_n low): rr_ptr=0, FIFO empty (rd_ptr=wr_ptr=0, count=0), err_orphan_resp=0.
- Reset mid-operation discards all in-flight IDs; responses arriving afterwards count as orphans.
- All outputs are combinational from state plus inputs, so every output is 0 while in reset with inputs idle.
- Arbitration:
  - Winner = first i with core_req_valid[i] set, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_CORES.
  - Purely combinational, zero-cycle latency.
- ram_req_valid = rdy & !fifo_full & |core_req_valid.
- ram_req_addr = winner's address slice; 0 when no request is valid.
- core_req_ready[i] = ram_req_valid & ram_req_ready & (winner==i). At most one bit is set.
- On handshake (ram_req_valid & ram_req_ready):
  - push winner index into the ID FIFO;
  - rr_ptr <= winner+1 (wraps from NUM_CORES-1 to 0).
- rr_ptr holds on cycles with no handshake.
- Response path:
  - When ram_resp_valid and FIFO not empty: core_resp_valid[head]=1 for the same cycle, core_resp_data=ram_resp_data, pop the head.
  - core_resp_data is driven from ram_resp_data unconditionally.
- Orphan response: ram_resp_valid with FIFO empty sets err_orphan_resp=1. The flag is sticky until reset; no core_resp_valid is raised.
- Full FIFO: no grant, even when a pop happens in the same cycle. Push is blocked when count==OUTSTANDING at the start of the cycle.
- Simultaneous push and pop when not full: both happen; count is unchanged.
- Pointers wrap modulo OUTSTANDING. count is ceil(log2(OUTSTANDING))+1 bits wide.
- rdy low: no grants and rr_ptr frozen. Responses are still accepted and routed, because RAM cannot be stalled.
- Request stability: a core may drop valid before it is granted. The arbiter makes no fairness guarantee for a dropped request.

Optional Feature:
- Macro: GELATO_ARB_STATS_EN.
- When defined:
  - Extra output port stat_grants (NUM_CORES*32).
  - Per-core 32-bit grant counter: increments on each handshake for that core, saturates at 0xFFFFFFFF.
  - Reset value 0.
  - Extra output stat_full_cycles (32): saturating count of cycles where a request was valid but the FIFO was full.
- When undefined: neither port nor any counters exist; behaviour is otherwise identical.

Decomposition:
- gelato_pkg holds:
  - core_id_t = logic [$clog2(NUM_CORES)-1:0];
  - ARB_STAT_WIDTH=32.
- One natural sub-module: gelato_id_fifo.
  - Parametrised depth/width synchronous FIFO.
  - Async active-low reset; exposes full, empty, head.
  - Instantiated once for the ID queue.

Test Plan (NUM_CORES=4, OUTSTANDING=4):
- Round-robin: all 4 cores hold valid (addresses 0x100, 0x200, 0x300, 0x400), ram_req_ready=1 -> grants go 0,1,2,3 on consecutive cycles and ram_req_addr follows in the same order; the FIFO then fills, so the 5th cycle has no grant.
- Ordered responses: after the above, 4 responses with data 0xA0..0xA3 on consecutive cycles -> core_resp_valid is 0001, 0010, 0100, 1000 with matching data; FIFO ends empty.
- Full FIFO with simultaneous pop: FIFO holds 4 entries, core 2 valid, response arrives -> no grant that cycle (count becomes 3); core 2 is granted the next cycle.
- rdy gating: rdy=0 with core 1 valid and ram_req_ready=1 -> ram_req_valid=0 and rr_ptr unchanged; a pending response is still delivered. rdy=1 -> core 1 is granted.
- Orphan and reset: response with FIFO empty -> err_orphan_resp=1 and stays 1. Assert rst_n=0 with 2 entries in flight -> FIFO empty and flag 0; a later response sets the flag again.
- Stats (GELATO_ARB_STATS_EN defined): 3 grants to core 0 and 1 grant to core 3 -> stat_grants slices read 3,0,0,1; counter preloaded near saturation stops at 0xFFFFFFFF.
